// File: rtl/btb_tagged_2bit_pkg.sv
// Shared counter encodings, FSM states and the saturating-counter helper for the tagged BTB.
package btb_tagged_2bit_pkg;

  localparam logic [1:0] BTB_CTR_SNT = 2'd0;
  localparam logic [1:0] BTB_CTR_WNT = 2'd1;
  localparam logic [1:0] BTB_CTR_WT  = 2'd2;
  localparam logic [1:0] BTB_CTR_ST  = 2'd3;

  typedef enum logic {
    BTB_ST_CLEAR = 1'b0,
    BTB_ST_RUN   = 1'b1
  } btb_state_t;

  // Saturating 2-bit step; never wraps between strongly-taken and strongly-not-taken.
  function automatic logic [1:0] btb_ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == BTB_CTR_ST) ? ctr : ctr + 2'd1;
    else
      return (ctr == BTB_CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_tagged_2bit_ram_2r1w.sv
// BTB entry storage: registered lookup read (read-first), combinational update probe, one write port.
module btb_ram_2r1w #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 53
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] pr_addr,
  output logic [DATA_WIDTH-1:0] pr_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Same-edge lookup sees the pre-write contents; there is deliberately no bypass.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  assign pr_data = mem[pr_addr];

endmodule

// File: rtl/btb_tagged_2bit.sv
// Tagged BTB with 2-bit direction counters: lookup in IF, registered {taken,target} in IG, trained from WA.
// A reset-triggered sweep invalidates every entry before the table reports ready.
module btb_tagged_2bit
  import btb_tagged_2bit_pkg::*;
#(
  parameter int PC_WIDTH    = 30,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lk_pc,
  output logic [PC_WIDTH:0]   pred,
  output logic                ready,
  input  logic                upd_en,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_branch,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target
);

  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;
  localparam int ENTRY_W   = 1 + TAG_WIDTH + 2 + PC_WIDTH;

  typedef struct packed {
    logic                 v;
    logic [TAG_WIDTH-1:0] tag;
    logic [1:0]           ctr;
    logic [PC_WIDTH-1:0]  target;
  } entry_t;

  btb_state_t             state, state_nxt;
  logic [INDEX_WIDTH-1:0] clr_idx, clr_idx_nxt;

  entry_t                 lk_ent, pr_ent, wr_ent;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic                   we;

  logic [TAG_WIDTH-1:0]   lk_tag_q;
  logic                   lk_live_q;

  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic                   upd_hit;
  logic                   lk_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BTB_ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    if (state == BTB_ST_CLEAR) begin
      clr_idx_nxt = clr_idx + 1'b1;
      if (clr_idx == '1)
        state_nxt = BTB_ST_RUN;
    end
  end

  assign ready = (state == BTB_ST_RUN);

  assign upd_idx = upd_pc[0+:INDEX_WIDTH];
  assign upd_tag = upd_pc[INDEX_WIDTH+:TAG_WIDTH];
  assign upd_hit = pr_ent.v && (pr_ent.tag == upd_tag);

  // Single write port: the clear sweep owns it; otherwise the read-modify-write of the update.
  always_comb begin
    we     = 1'b0;
    wr_idx = clr_idx;
    wr_ent = '0;
    if (state == BTB_ST_CLEAR) begin
      we = !rst;
    end else if (upd_en && !rst) begin
      wr_idx = upd_idx;
      if (upd_hit && upd_branch) begin
        we         = 1'b1;
        wr_ent     = pr_ent;
        wr_ent.ctr = btb_ctr_next(pr_ent.ctr, upd_taken);
        if (upd_taken)
          wr_ent.target = upd_target;
      end else if (upd_hit) begin
        we       = 1'b1;
        wr_ent   = pr_ent;
        wr_ent.v = 1'b0;
      end else if (upd_branch && upd_taken) begin
        we            = 1'b1;
        wr_ent.v      = 1'b1;
        wr_ent.tag    = upd_tag;
        wr_ent.ctr    = BTB_CTR_WT;
        wr_ent.target = upd_target;
      end
    end
  end

  btb_ram_2r1w #(
    .ADDR_WIDTH(INDEX_WIDTH),
    .DATA_WIDTH(ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (lk_pc[0+:INDEX_WIDTH]),
    .rd_data (lk_ent),
    .pr_addr (upd_idx),
    .pr_data (pr_ent),
    .we      (we),
    .wr_addr (wr_idx),
    .wr_data (wr_ent)
  );

  // lk_live_q masks the prediction for lookups issued during the sweep or under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_tag_q  <= '0;
      lk_live_q <= 1'b0;
    end else begin
      lk_tag_q  <= lk_pc[INDEX_WIDTH+:TAG_WIDTH];
      lk_live_q <= (state == BTB_ST_RUN);
    end
  end

  assign lk_hit = lk_live_q && lk_ent.v && (lk_ent.tag == lk_tag_q);
  assign pred   = (lk_hit && lk_ent.ctr[1]) ? {1'b1, lk_ent.target} : '0;

endmodule
